dividend_reconstructor: RTL and testbench

//  Inverse of the divider datapath: rebuilds dividend S = Q*D + R from a quotient/remainder/divisor triple.

---
 rtl/dividend_reconstructor_pkg.sv | 16 +
 rtl/recon_shift_add_step.sv | 32 +++
 rtl/dividend_reconstructor.sv | 110 +++++++++++
 tb/tb_dividend_reconstructor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dividend_reconstructor_pkg.sv
// Shared types and default widths for the dividend reconstructor.
// The state enum is also visible to the bench via the debug port.
package dividend_reconstructor_pkg;

   localparam int QW_DEF = 8;
   localparam int DW_DEF = 5;
   localparam int SW_DEF = 13;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ADDR = 2'd2,
      S_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/recon_shift_add_step.sv
// One shift-add step: a + (qbit ? d << cnt : 0).
// The carry flags any sum bit at or above bit SW, including D bits shifted past SW.
module recon_shift_add_step #(
   parameter int QW = 8,
   parameter int DW = 5,
   parameter int SW = 13,
   parameter int CW = 3
) (
   input  logic [SW-1:0] i_a,
   input  logic [DW-1:0] i_d,
   input  logic [CW-1:0] i_cnt,
   input  logic          i_qbit,
   output logic [SW-1:0] o_a,
   output logic          o_carry
);

   // Wide enough that neither the shifted addend nor the sum can lose bits.
   localparam int WW = SW + DW + QW + 1;

   logic [WW-1:0] w_add;
   logic [WW-1:0] w_sum;

   always_comb begin
      w_add = '0;
      if (i_qbit) w_add = WW'(i_d) << i_cnt;
      w_sum = WW'(i_a) + w_add;
   end

   assign o_a     = w_sum[SW-1:0];
   assign o_carry = |w_sum[WW-1:SW];

endmodule

// File: rtl/dividend_reconstructor.sv
// Rebuilds S = Q*D + R with an LSB-first shift-add loop and a final remainder add.
// Results and flags are registered as ADDR completes so they are valid during the done cycle.
module dividend_reconstructor
   import dividend_reconstructor_pkg::*;
#(
   parameter int QW = QW_DEF,
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lds,
   input  logic          startm,
   input  logic [QW-1:0] quo,
   input  logic [DW-1:0] rem,
   input  logic [DW-1:0] dives,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] s_out,
   output logic          ovf,
   output logic          bad,
   output state_t        o_dbg_state
);

   localparam int CW = (QW > 1) ? $clog2(QW) : 1;

   state_t        r_state;
   logic [QW-1:0] r_quo;
   logic [DW-1:0] r_rem;
   logic [DW-1:0] r_div;
   logic [QW-1:0] r_q;
   logic [SW:0]   r_acc;
   logic [CW-1:0] r_cnt;

   logic [DW-1:0] w_d;
   logic [CW-1:0] w_cnt;
   logic          w_qbit;
   logic [SW-1:0] w_sum;
   logic          w_carry;

   // ADDR reuses the step with the remainder as an unshifted addend.
   assign w_d    = (r_state == S_ADDR) ? r_rem : r_div;
   assign w_cnt  = (r_state == S_ADDR) ? '0 : r_cnt;
   assign w_qbit = (r_state == S_ADDR) ? 1'b1 : r_q[0];

   recon_shift_add_step #(.QW(QW), .DW(DW), .SW(SW), .CW(CW)) u_step (
      .i_a     (r_acc[SW-1:0]),
      .i_d     (w_d),
      .i_cnt   (w_cnt),
      .i_qbit  (w_qbit),
      .o_a     (w_sum),
      .o_carry (w_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_quo   <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_q     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s_out   <= '0;
         ovf     <= 1'b0;
         bad     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (lds) begin
                  r_quo <= quo;
                  r_rem <= rem;
                  r_div <= dives;
               end else if (startm) begin
                  r_acc   <= '0;
                  r_q     <= r_quo;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               r_acc <= {r_acc[SW] | w_carry, w_sum};
               r_q   <= r_q >> 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(QW - 1)) r_state <= S_ADDR;
            end
            S_ADDR: begin
               r_acc   <= {r_acc[SW] | w_carry, w_sum};
               s_out   <= w_sum;
               ovf     <= r_acc[SW] | w_carry;
               bad     <= (r_div == '0) || (r_rem >= r_div);
               done    <= 1'b1;
               r_state <= S_FIN;
            end
            S_FIN: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dividend_reconstructor.sv
// Directed and randomized checks of the dividend reconstructor against Q*D+R arithmetic.
module tb_dividend_reconstructor;
   import dividend_reconstructor_pkg::*;

   localparam int QW  = QW_DEF;
   localparam int DW  = DW_DEF;
   localparam int SW  = SW_DEF;
   localparam int LAT = QW + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lds = 1'b0;
   logic          startm = 1'b0;
   logic [QW-1:0] quo = '0;
   logic [DW-1:0] rem = '0;
   logic [DW-1:0] dives = '0;
   logic          busy, done, ovf, bad;
   logic [SW-1:0] s_out;
   state_t        dbg_state;

   int n_vec = 0;
   int n_err = 0;

   // Reference operands as the DUT should currently hold them.
   int unsigned m_q = 0, m_d = 0, m_r = 0;
   // Expected {bad, ovf, s_out} per accepted start.
   logic [SW+1:0] exp_q[$];

   dividend_reconstructor dut (
      .clk(clk), .rst(rst), .lds(lds), .startm(startm),
      .quo(quo), .rem(rem), .dives(dives),
      .busy(busy), .done(done), .s_out(s_out), .ovf(ovf), .bad(bad),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [SW+1:0] model(input int unsigned q, d, r);
      longint unsigned full;
      logic [SW-1:0] s;
      logic o, b;
      full = longint'(q) * longint'(d) + longint'(r);
      s = SW'(full);
      o = (full > ((64'd1 << SW) - 1));
      b = (d == 0) || (r >= d);
      return {b, o, s};
   endfunction

   task automatic do_load(input int unsigned q, d, r);
      lds = 1'b1; quo = QW'(q); dives = DW'(d); rem = DW'(r);
      @(negedge clk);
      lds = 1'b0;
      m_q = q; m_d = d; m_r = r;
   endtask

   task automatic do_start();
      startm = 1'b1;
      @(negedge clk);
      startm = 1'b0;
      exp_q.push_back(model(m_q, m_d, m_r));
   endtask

   // Called in the first cycle after the start edge; returns at the done cycle.
   task automatic wait_result(input string tag, input bit chk_lat);
      int lat, bcnt;
      logic [SW+1:0] e;
      lat = 1; bcnt = 0;
      while (!done && lat <= 3 * LAT) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (busy) bcnt++;
      chk({tag, " done"}, 32'(done), 1);
      if (chk_lat) begin
         chk({tag, " latency"}, lat, LAT);
         chk({tag, " busy_cycles"}, bcnt, LAT);
      end
      if (done && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, " s_out"}, 32'(s_out), 32'(e[SW-1:0]));
         chk({tag, " ovf"}, 32'(ovf), 32'(e[SW]));
         chk({tag, " bad"}, 32'(bad), 32'(e[SW+1]));
      end
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(done), 0);
      chk({tag, " busy_clear"}, 32'(busy), 0);
   endtask

   task automatic run(input string tag, input int unsigned q, d, r);
      do_load(q, d, r);
      do_start();
      wait_result(tag, 1'b1);
      after_done(tag);
   endtask

   initial begin
      int seen;
      logic [SW-1:0] held;
      // clock/reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset s_out", 32'(s_out), 0);
      chk("reset ovf", 32'(ovf), 0);
      chk("reset bad", 32'(bad), 0);
      chk("reset state", 32'(dbg_state), 32'(S_IDLE));

      run("t1", 25, 7, 3);
      chk("t1 abs", 32'(s_out), 178);
      run("t2", 255, 31, 30);
      chk("t2 abs", 32'(s_out), 7935);
      run("t3a", 0, 9, 4);
      run("t3b", 0, 0, 0);
      run("t4a", 10, 5, 5);
      chk("t4a abs", 32'(s_out), 55);

      // Load and start in one cycle: only the load takes effect.
      held = s_out;
      lds = 1'b1; startm = 1'b1; quo = 8'd3; dives = 5'd4; rem = 5'd1;
      @(negedge clk);
      lds = 1'b0; startm = 1'b0;
      m_q = 3; m_d = 4; m_r = 1;
      for (int i = 0; i < 4; i++) begin
         chk("t4b busy_idle", 32'(busy), 0);
         @(negedge clk);
      end
      chk("t4b s_out_held", 32'(s_out), 32'(held));
      do_start();
      wait_result("t4b", 1'b1);
      after_done("t4b");

      // Reset during MUL cycle 4 aborts the run and zeroes operands.
      do_load(25, 7, 3);
      do_start();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5 busy", 32'(busy), 0);
      chk("t5 s_out", 32'(s_out), 0);
      chk("t5 done", 32'(done), 0);
      exp_q.delete();
      m_q = 0; m_d = 0; m_r = 0;
      seen = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         if (done) seen++;
         @(negedge clk);
      end
      chk("t5 no_done", seen, 0);
      do_start();
      wait_result("t5b", 1'b1);
      chk("t5b bad_abs", 32'(bad), 1);
      after_done("t5b");

      // Mid-run load/start ignored, then back-to-back start.
      do_load(200, 19, 11);
      do_start();
      @(negedge clk);
      lds = 1'b1; startm = 1'b1; quo = 8'd1; dives = 5'd2; rem = 5'd1;
      @(negedge clk);
      lds = 1'b0; startm = 1'b0;
      wait_result("t6a", 1'b0);
      chk("t6a abs", 32'(s_out), 3811);
      after_done("t6a");
      do_start();
      wait_result("t6b", 1'b1);
      chk("t6b abs", 32'(s_out), 3811);
      after_done("t6b");

      // Randomized triples, biased so some are invalid.
      for (int i = 0; i < 24; i++) begin
         int unsigned q, d, r;
         q = $urandom_range(0, (1 << QW) - 1);
         d = $urandom_range(0, (1 << DW) - 1);
         r = (i % 4 == 0) ? $urandom_range(0, (1 << DW) - 1)
                          : ((d == 0) ? 0 : $urandom_range(0, d - 1));
         run("rand", q, d, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
